// File: rtl/pe_issuer_pkg.sv
// Shared PE definitions: opcode encoding and issuer FSM states.
// Used by the issuer and the PE controller.
package pe_issuer_pkg;

   typedef enum logic [1:0] {
      OP_REST = 2'b00,
      OP_WGET = 2'b01,
      OP_M16  = 2'b10,
      OP_M8   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Width able to hold values 0..n, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pe_issuer_if.sv
// Command, data and instruction-stream bundle between the issuer and its neighbours.
interface pe_issuer_if #(
   parameter int unsigned LEN_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [LEN_W-1:0] cmd_len;
   logic             din_valid;
   logic             din_ready;
   logic [15:0]      din;
   logic [1:0]       ISout;
   logic [15:0]      Xout;
   logic             busy;
   logic             done;

   modport master (
      output cmd_valid, cmd_op, cmd_len, din_valid, din,
      input  cmd_ready, din_ready, ISout, Xout, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_len, din_valid, din,
      output cmd_ready, din_ready, ISout, Xout, busy, done
   );
endinterface

// File: rtl/pe_issuer.sv
// Turns a command plus a stream of data words into the registered ISout/Xout
// instruction stream for the PE controller, with a rest drain after compute ops.
module pe_issuer
   import pe_issuer_pkg::*;
#(
   parameter int unsigned DRAIN_CYC = 4,
   parameter int unsigned LEN_W     = 8
) (
   input  logic        clk,
   input  logic        rst,
   pe_issuer_if.slave  bus
);

   localparam int unsigned DW = cnt_width(DRAIN_CYC);

   state_e           state, state_nxt;
   op_e              op_q;
   logic [LEN_W-1:0] beat_cnt;
   logic [DW-1:0]    drain_cnt;
   logic             last_beat;

   assign last_beat = bus.din_valid && (beat_cnt == LEN_W'(1));

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (bus.cmd_valid) begin
               if (bus.cmd_op == OP_REST || bus.cmd_len == '0) state_nxt = ST_DONE;
               else                                            state_nxt = ST_ISSUE;
            end
         ST_ISSUE:
            if (last_beat) begin
               if (op_q == OP_WGET || DRAIN_CYC == 0) state_nxt = ST_DONE;
               else                                   state_nxt = ST_DRAIN;
            end
         ST_DRAIN:
            if (drain_cnt <= DW'(1)) state_nxt = ST_DONE;
         ST_DONE:
            state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = (state == ST_IDLE);
      bus.din_ready = (state == ST_ISSUE);
      bus.busy      = (state != ST_IDLE);
      bus.done      = (state == ST_DONE);
   end

   // Every cycle without a data handshake registers a rest slot, which covers
   // idle, bubbles, drain and done alike.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= OP_REST;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         bus.ISout <= OP_REST;
         bus.Xout  <= '0;
      end else begin
         bus.ISout <= OP_REST;
         bus.Xout  <= '0;
         case (state)
            ST_IDLE:
               if (bus.cmd_valid) begin
                  op_q     <= op_e'(bus.cmd_op);
                  beat_cnt <= bus.cmd_len;
               end
            ST_ISSUE:
               if (bus.din_valid) begin
                  bus.ISout <= op_q;
                  bus.Xout  <= bus.din;
                  if (beat_cnt > LEN_W'(1)) beat_cnt <= beat_cnt - LEN_W'(1);
                  if (last_beat) drain_cnt <= DW'(DRAIN_CYC);
               end
            ST_DRAIN:
               if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_issuer.sv
// Directed self-checking bench for pe_issuer (DRAIN_CYC=4, LEN_W=8).
module tb_pe_issuer;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   pe_issuer_if #(.LEN_W(8)) bus();

   pe_issuer #(.DRAIN_CYC(4), .LEN_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] len);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_len   = len;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests++; if (bus.ISout !== 2'b00) begin fails++; $display("FAIL reset_isout got %b want 00", bus.ISout); end
      tests++; if (bus.Xout !== 16'h0000) begin fails++; $display("FAIL reset_xout got %h want 0000", bus.Xout); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
      rst = 1'b0;
   endtask

   task automatic test_wget();
      logic [15:0] d [3] = '{16'h0001, 16'h7FFF, 16'h8000};
      send_cmd(2'b01, 8'd3);
      bus.din_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.din = d[i];
         tick();
         tests++; if (bus.ISout !== 2'b01) begin fails++; $display("FAIL wget_isout beat%0d got %b want 01", i, bus.ISout); end
         tests++; if (bus.Xout !== d[i]) begin fails++; $display("FAIL wget_xout beat%0d got %h want %h", i, bus.Xout, d[i]); end
         tests++; if (bus.done !== (i == 2)) begin fails++; $display("FAIL wget_done beat%0d got %b want %b", i, bus.done, (i == 2)); end
      end
      bus.din_valid = 1'b0;
      tick();
      tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL wget_end done/busy got %b%b want 00", bus.done, bus.busy); end
      tests++; if (bus.ISout !== 2'b00) begin fails++; $display("FAIL wget_end_isout got %b want 00", bus.ISout); end
   endtask

   task automatic test_m16_drain();
      send_cmd(2'b10, 8'd2);
      bus.din_valid = 1'b1;
      bus.din = 16'hFFFE;
      tick();
      tests++; if (bus.ISout !== 2'b10 || bus.Xout !== 16'hFFFE) begin fails++; $display("FAIL m16_beat0 got %b/%h want 10/fffe", bus.ISout, bus.Xout); end
      bus.din = 16'h0005;
      tick();
      tests++; if (bus.ISout !== 2'b10 || bus.Xout !== 16'h0005) begin fails++; $display("FAIL m16_beat1 got %b/%h want 10/0005", bus.ISout, bus.Xout); end
      bus.din_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++; if (bus.ISout !== 2'b00 || bus.Xout !== 16'h0000) begin fails++; $display("FAIL m16_drain%0d got %b/%h want 00/0000", i, bus.ISout, bus.Xout); end
         tests++; if (bus.done !== (i == 3)) begin fails++; $display("FAIL m16_done%0d got %b want %b", i, bus.done, (i == 3)); end
      end
      tick();
      tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL m16_end busy/done got %b%b want 00", bus.busy, bus.done); end
   endtask

   task automatic test_m8_bubble();
      logic        dv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [15:0] dd [5] = '{16'h0101, 16'hDEAD, 16'h0202, 16'h0303, 16'h0404};
      logic [1:0]  exp_is;
      logic [15:0] exp_x;
      int          beats = 0;
      send_cmd(2'b11, 8'd4);
      for (int i = 0; i < 5; i++) begin
         bus.din_valid = dv[i];
         bus.din       = dd[i];
         tick();
         exp_is = dv[i] ? 2'b11 : 2'b00;
         exp_x  = dv[i] ? dd[i] : 16'h0000;
         if (bus.ISout === 2'b11) beats++;
         tests++; if (bus.ISout !== exp_is || bus.Xout !== exp_x) begin fails++; $display("FAIL m8_step%0d got %b/%h want %b/%h", i, bus.ISout, bus.Xout, exp_is, exp_x); end
      end
      bus.din_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.ISout === 2'b11) beats++;
      end
      tests++; if (beats != 4) begin fails++; $display("FAIL m8_beat_count got %0d want 4", beats); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL m8_end_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_nop_and_zero_len();
      logic [1:0] ops [2] = '{2'b00, 2'b10};
      logic [7:0] lens [2] = '{8'd5, 8'd0};
      for (int k = 0; k < 2; k++) begin
         bus.din_valid = 1'b1;
         bus.din       = 16'h1234;
         send_cmd(ops[k], lens[k]);
         tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL nop%0d_done got %b want 1", k, bus.done); end
         tests++; if (bus.din_ready !== 1'b0 || bus.ISout !== 2'b00) begin fails++; $display("FAIL nop%0d_din_ready/isout got %b/%b want 0/00", k, bus.din_ready, bus.ISout); end
         tick();
         tests++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.ISout !== 2'b00) begin fails++; $display("FAIL nop%0d_after done/ready/isout got %b/%b/%b want 0/1/00", k, bus.done, bus.cmd_ready, bus.ISout); end
         bus.din_valid = 1'b0;
      end
   endtask

   task automatic test_reset_abort();
      int stray = 0;
      send_cmd(2'b11, 8'd5);
      bus.din_valid = 1'b1;
      bus.din = 16'h0011;
      tick();
      bus.din = 16'h0022;
      tick();
      tests++; if (bus.ISout !== 2'b11 || bus.Xout !== 16'h0022) begin fails++; $display("FAIL abort_beat2 got %b/%h want 11/0022", bus.ISout, bus.Xout); end
      rst = 1'b1;
      bus.din = 16'h0033;
      tick();
      tests++; if (bus.ISout !== 2'b00 || bus.Xout !== 16'h0000) begin fails++; $display("FAIL abort_out got %b/%h want 00/0000", bus.ISout, bus.Xout); end
      tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL abort_done/busy got %b%b want 00", bus.done, bus.busy); end
      rst = 1'b0;
      #1;
      tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL abort_cmd_ready got %b want 1", bus.cmd_ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.ISout !== 2'b00 || bus.done !== 1'b0) stray++;
      end
      tests++; if (stray != 0) begin fails++; $display("FAIL abort_stray got %0d want 0", stray); end
      bus.din_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int cyc = 0;
      int bad = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b01;
      bus.cmd_len   = 8'd1;
      bus.din_valid = 1'b1;
      bus.din       = 16'hAAAA;
      tick();
      bus.cmd_op  = 2'b11;
      bus.cmd_len = 8'd255;
      tests++; if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_issue ready/busy got %b/%b want 0/1", bus.cmd_ready, bus.busy); end
      tick();
      tests++; if (bus.ISout !== 2'b01 || bus.Xout !== 16'hAAAA || bus.done !== 1'b1) begin fails++; $display("FAIL b2b_first got %b/%h/%b want 01/aaaa/1", bus.ISout, bus.Xout, bus.done); end
      tick();
      tests++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin fails++; $display("FAIL b2b_idle ready/done got %b/%b want 1/0", bus.cmd_ready, bus.done); end
      tick();
      tests++; if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_second_accept ready/busy got %b/%b want 0/1", bus.cmd_ready, bus.busy); end
      bus.cmd_valid = 1'b0;
      bus.din = 16'(n);
      while (cyc < 400) begin
         tick();
         cyc++;
         if (bus.ISout === 2'b11) begin
            if (bus.Xout !== 16'(n)) bad++;
            n++;
            bus.din = 16'(n);
         end
         if (bus.done === 1'b1) break;
      end
      bus.din_valid = 1'b0;
      tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL b2b_timeout done got %b want 1 within 400 cycles", bus.done); end
      tests++; if (n != 255) begin fails++; $display("FAIL b2b_len255 beats got %0d want 255", n); end
      tests++; if (bad != 0) begin fails++; $display("FAIL b2b_data bad beats got %0d want 0", bad); end
      tests++; if (cyc != 259) begin fails++; $display("FAIL b2b_done_cycle got %0d want 259", cyc); end
      tick();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_end_busy got %b want 0", bus.busy); end
   endtask

   initial begin
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_len   = 8'd0;
      bus.din_valid = 1'b0;
      bus.din       = 16'h0000;
      test_reset();
      tick();
      test_wget();
      tick();
      test_m16_drain();
      tick();
      test_m8_bubble();
      tick();
      test_nop_and_zero_len();
      tick();
      test_reset_abort();
      tick();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
